// File: rtl/div_freq_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   MIN_DIV  : smallest divisor a config write may program.
//   mode_e   : output shape per channel (square or single pulse).
//   half_up  : ceil(d/2), the high-time of a square-wave period.
package div_freq_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Evaluated at 64 bits so callers of any WIDTH up to 64 can zero-extend in and truncate out.
  function automatic logic [63:0] half_up(input logic [63:0] d);
    return (d >> 1) + {63'd0, d[0]};
  endfunction

endpackage

// File: rtl/div_freq_multi_if.sv
// Config/control/status bundle of div_freq_multi.
//   Din, conf_div, conf_mode, ch_sel : config write (divisor, strobe, mode, target channel)
//   ctrl_tr_dat                      : per-channel run enable
//   clk_out, tick, pending, cfg_err  : per-channel outputs and config-reject pulse
// master = the controller driving config, slave = the divider.
interface div_freq_multi_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CH_W  = 2
);
  logic [WIDTH-1:0] Din;
  logic             conf_div;
  logic             conf_mode;
  logic [CH_W-1:0]  ch_sel;
  logic [N_CH-1:0]  ctrl_tr_dat;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pending;
  logic             cfg_err;

  modport master (
    output Din, conf_div, conf_mode, ch_sel, ctrl_tr_dat,
    input  clk_out, tick, pending, cfg_err
  );

  modport slave (
    input  Din, conf_div, conf_mode, ch_sel, ctrl_tr_dat,
    output clk_out, tick, pending, cfg_err
  );
endinterface

// File: rtl/div_freq_ch.sv
// One divider channel: period counter, active/shadow divisor and mode, registered outputs.
//   clk, reset : system clock, async active-low reset
//   en         : run enable; low parks the counter at D-1 and forces outputs low
//   wr         : validated config write addressed to this channel
//   din        : divisor for the write; mode_in : mode for the write
//   clk_out    : divided output; tick : first cycle of each period
//   pending    : a shadow divisor waits for the next period boundary
module div_freq_ch
  import div_freq_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             mode_in,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [WIDTH-1:0] d_q, d_nxt, sh_q, sh_nxt, cnt_q, cnt_nxt, half;
  mode_e            mode_q, mode_nxt, shm_q, shm_nxt;
  logic             pend_q, pend_nxt, clk_q, clk_nxt, tick_q, tick_nxt, wrap;

  always_comb begin
    d_nxt    = d_q;
    mode_nxt = mode_q;
    sh_nxt   = sh_q;
    shm_nxt  = shm_q;
    pend_nxt = pend_q;
    cnt_nxt  = cnt_q;
    clk_nxt  = 1'b0;
    tick_nxt = 1'b0;
    wrap     = en && (cnt_q == d_q - 1'b1);

    // A parked or wrapping counter is a safe point to switch divisor: take the write directly,
    // otherwise promote a waiting shadow. Mid-period writes only land in the shadow.
    if (!en || wrap) begin
      if (wr) begin
        d_nxt    = din;
        mode_nxt = mode_e'(mode_in);
        sh_nxt   = din;
        shm_nxt  = mode_e'(mode_in);
      end else if (pend_q) begin
        d_nxt    = sh_q;
        mode_nxt = shm_q;
      end
      pend_nxt = 1'b0;
    end else if (wr) begin
      sh_nxt   = din;
      shm_nxt  = mode_e'(mode_in);
      pend_nxt = 1'b1;
    end

    half = WIDTH'(half_up(64'(d_nxt)));

    if (!en) begin
      cnt_nxt = d_nxt - 1'b1;
    end else begin
      cnt_nxt  = wrap ? '0 : cnt_q + 1'b1;
      tick_nxt = (cnt_nxt == '0);
      clk_nxt  = (mode_nxt == MODE_PULSE) ? (cnt_nxt == '0) : (cnt_nxt < half);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q    <= WIDTH'(DEF_DIV);
      sh_q   <= WIDTH'(DEF_DIV);
      mode_q <= MODE_SQUARE;
      shm_q  <= MODE_SQUARE;
      cnt_q  <= WIDTH'(DEF_DIV - 1);
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      d_q    <= d_nxt;
      sh_q   <= sh_nxt;
      mode_q <= mode_nxt;
      shm_q  <= shm_nxt;
      cnt_q  <= cnt_nxt;
      pend_q <= pend_nxt;
      clk_q  <= clk_nxt;
      tick_q <= tick_nxt;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/div_freq_multi.sv
// Multi-channel programmable clock divider.
//   clk, reset : system clock, async active-low reset
//   bus        : config write, run enables, per-channel outputs and cfg_err (div_freq_multi_if)
// Config writes are validated here (divisor >= MIN_DIV, channel in range); rejected writes
// raise cfg_err for one cycle and touch nothing. Accepted writes go to one div_freq_ch.
module div_freq_multi
  import div_freq_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic           clk,
  input  logic           reset,
  div_freq_multi_if.slave bus
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  // One extra bit so N_CH itself is representable when it is a power of two.
  localparam logic [CH_W:0] NChLim = (CH_W + 1)'(N_CH);

  logic            din_ok, sel_ok, valid, err_q;
  logic [N_CH-1:0] wr, clk_out_v, tick_v, pend_v;

  assign din_ok = (bus.Din >= WIDTH'(MIN_DIV));
  assign sel_ok = ({1'b0, bus.ch_sel} < NChLim);
  assign valid  = bus.conf_div && din_ok && sel_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= bus.conf_div && !valid;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr[i] = valid && (bus.ch_sel == CH_W'(i));

    div_freq_ch #(
      .WIDTH  (WIDTH),
      .DEF_DIV(DEF_DIV)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (bus.ctrl_tr_dat[i]),
      .wr     (wr[i]),
      .din    (bus.Din),
      .mode_in(bus.conf_mode),
      .clk_out(clk_out_v[i]),
      .tick   (tick_v[i]),
      .pending(pend_v[i])
    );
  end

  assign bus.clk_out = clk_out_v;
  assign bus.tick    = tick_v;
  assign bus.pending = pend_v;
  assign bus.cfg_err = err_q;

endmodule
